// File: rtl/stump_control_ws.sv
// Stump control unit with memory wait states, bus timeout error and a retired-instruction counter.
// Decode outputs are combinational from state, ir, cc and mem_ready. State and counters update on posedge clk.
module stump_control_ws #(
  parameter int         WAIT_MAX = 15,
  parameter int         CNT_W    = 16,
  parameter logic [2:0] PC_REG   = 3'd7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cc,
  input  logic [15:0]      ir,
  input  logic             mem_ready,
  output logic             fetch,
  output logic             execute,
  output logic             memory,
  output logic             bus_error,
  output logic             ext_op,
  output logic             reg_write,
  output logic [2:0]       dest,
  output logic [2:0]       srcA,
  output logic [2:0]       srcB,
  output logic [1:0]       shift_op,
  output logic             opB_mux_sel,
  output logic [2:0]       alu_func,
  output logic             cc_en,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXECUTE,
    S_MEMORY,
    S_ERROR
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       taken;

  logic [2:0] op;
  logic       ir_type;
  logic       ir_s;
  logic [2:0] fd, fa, fb;
  logic [1:0] fsh;
  logic [3:0] cond;

  assign op      = ir[15:13];
  assign ir_type = ir[12];
  assign ir_s    = ir[11];
  assign fd      = ir[10:8];
  assign fa      = ir[7:5];
  assign fb      = ir[4:2];
  assign fsh     = ir[1:0];
  assign cond    = ir[11:8];

  // cc = {N,Z,V,C}
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = 1'b1;
      4'h1: taken = 1'b0;
      4'h2: taken = !cc[0] && !cc[2];
      4'h3: taken = cc[0] || cc[2];
      4'h4: taken = !cc[0];
      4'h5: taken = cc[0];
      4'h6: taken = !cc[2];
      4'h7: taken = cc[2];
      4'h8: taken = !cc[1];
      4'h9: taken = cc[1];
      4'hA: taken = !cc[3];
      4'hB: taken = cc[3];
      4'hC: taken = (cc[3] == cc[1]);
      4'hD: taken = (cc[3] != cc[1]);
      4'hE: taken = !cc[2] && (cc[3] == cc[1]);
      4'hF: taken = cc[2] || (cc[3] != cc[1]);
      default: taken = 1'b0;
    endcase
  end

  assign waiting = ((state == S_FETCH) || (state == S_MEMORY)) && !mem_ready;

  // A ready on the final allowed wait cycle still completes the access.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)                state_nxt = S_EXECUTE;
        else if (wait_cnt == WAIT_LIM) state_nxt = S_ERROR;
      end
      S_EXECUTE: state_nxt = (op == 3'b110) ? S_MEMORY : S_FETCH;
      S_MEMORY: begin
        if (mem_ready)                state_nxt = S_FETCH;
        else if (wait_cnt == WAIT_LIM) state_nxt = S_ERROR;
      end
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= 8'd0;
      else if (waiting)       wait_cnt <= wait_cnt + 8'd1;
      if (((state == S_EXECUTE) || (state == S_MEMORY)) && (state_nxt == S_FETCH))
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    fetch       = 1'b0;
    execute     = 1'b0;
    memory      = 1'b0;
    bus_error   = 1'b0;
    ext_op      = 1'b0;
    reg_write   = 1'b0;
    dest        = 3'd0;
    srcA        = 3'd0;
    srcB        = 3'd0;
    shift_op    = 2'b00;
    opB_mux_sel = 1'b0;
    alu_func    = 3'd0;
    cc_en       = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    case (state)
      S_FETCH: begin
        fetch   = 1'b1;
        mem_ren = 1'b1;
      end
      S_EXECUTE: begin
        execute = 1'b1;
        if (op == 3'b111) begin
          srcA        = PC_REG;
          dest        = PC_REG;
          opB_mux_sel = 1'b1;
          ext_op      = 1'b1;
          reg_write   = taken;
        end else begin
          srcA        = fa;
          srcB        = fb;
          opB_mux_sel = ir_type;
          shift_op    = ir_type ? 2'b00 : fsh;
          if (op != 3'b110) begin
            alu_func  = op;
            dest      = fd;
            cc_en     = ir_s;
            reg_write = 1'b1;
          end
        end
      end
      S_MEMORY: begin
        memory = 1'b1;
        dest   = fd;
        srcB   = fb;
        if (ir_s) begin
          mem_wen = 1'b1;
          srcA    = fd;
        end else begin
          mem_ren   = 1'b1;
          srcA      = fa;
          reg_write = mem_ready;
        end
      end
      S_ERROR:  bus_error = 1'b1;
      default:  bus_error = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_stump_control_ws.sv
// Directed bench for stump_control_ws with WAIT_MAX=3 and a 4-bit retired counter.
module tb_stump_control_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cc;
  logic [15:0] ir;
  logic        mem_ready;
  logic        fetch, execute, memory, bus_error, ext_op, reg_write;
  logic [2:0]  dest, srcA, srcB, alu_func;
  logic [1:0]  shift_op;
  logic        opB_mux_sel, cc_en, mem_ren, mem_wen;
  logic [3:0]  retired;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_ret;

  stump_control_ws #(.WAIT_MAX(3), .CNT_W(4), .PC_REG(3'd7)) dut (
    .clk(clk), .rst(rst), .cc(cc), .ir(ir), .mem_ready(mem_ready),
    .fetch(fetch), .execute(execute), .memory(memory), .bus_error(bus_error),
    .ext_op(ext_op), .reg_write(reg_write), .dest(dest), .srcA(srcA), .srcB(srcB),
    .shift_op(shift_op), .opB_mux_sel(opB_mux_sel), .alu_func(alu_func),
    .cc_en(cc_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  alu, d, a, b;
    logic [1:0]  sh;
    logic        opb, ccen;
  } alu_vec_t;

  typedef struct {
    logic [3:0]  cond;
    logic [15:0] mask;
  } br_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ret = 4'd0;
  endtask

  // One FETCH cycle with zero wait states, leaving the DUT in EXECUTE.
  task automatic do_fetch(input logic [15:0] instr);
    ir = instr;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", {fetch, execute, memory, mem_ren}, 4'b1001);
    tick();
  endtask

  alu_vec_t av[4];
  br_vec_t  bv[16];

  initial begin
    av[0] = '{16'h25DD, 3'd1, 3'd5, 3'd6, 3'd7, 2'd1, 1'b0, 1'b0};
    av[1] = '{16'hB8EB, 3'd5, 3'd0, 3'd7, 3'd2, 2'd0, 1'b1, 1'b1};
    av[2] = '{16'h6B86, 3'd3, 3'd3, 3'd4, 3'd1, 2'd2, 1'b0, 1'b1};
    av[3] = '{16'h8717, 3'd4, 3'd7, 3'd0, 3'd5, 2'd3, 1'b0, 1'b0};

    // bit i of mask = taken for cc value i, cc = {N,Z,V,C}
    bv[0]  = '{4'h0, 16'hFFFF}; bv[1]  = '{4'h1, 16'h0000};
    bv[2]  = '{4'h2, 16'h0505}; bv[3]  = '{4'h3, 16'hFAFA};
    bv[4]  = '{4'h4, 16'h5555}; bv[5]  = '{4'h5, 16'hAAAA};
    bv[6]  = '{4'h6, 16'h0F0F}; bv[7]  = '{4'h7, 16'hF0F0};
    bv[8]  = '{4'h8, 16'h3333}; bv[9]  = '{4'h9, 16'hCCCC};
    bv[10] = '{4'hA, 16'h00FF}; bv[11] = '{4'hB, 16'hFF00};
    bv[12] = '{4'hC, 16'hCC33}; bv[13] = '{4'hD, 16'h33CC};
    bv[14] = '{4'hE, 16'h0C03}; bv[15] = '{4'hF, 16'hF3FC};

    cc = 4'h0;
    ir = 16'h0000;
    mem_ready = 1'b0;
    rst = 1'b1;
    #3;
    chk("rst_state", {fetch, execute, memory, bus_error}, 4'b1000);
    chk("rst_mem", {mem_ren, mem_wen, reg_write, cc_en}, 4'b1000);
    chk("rst_retired", retired, 0);
    do_reset();

    // ADD R1,R2,R3 with S=1
    do_fetch(16'h094C);
    chk("add_exec", execute, 1);
    chk("add_regs", {dest, srcA, srcB}, {3'd1, 3'd2, 3'd3});
    chk("add_en", {cc_en, reg_write, ext_op, opB_mux_sel}, 4'b1100);
    tick();
    exp_ret = exp_ret + 4'd1;
    chk("add_retired", retired, exp_ret);
    chk("add_back_fetch", fetch, 1);

    for (int i = 0; i < 4; i++) begin
      do_fetch(av[i].ir);
      mem_ready = 1'b0;
      #1;
      chk("alu_fields", {alu_func, dest, srcA, srcB, shift_op},
          {av[i].alu, av[i].d, av[i].a, av[i].b, av[i].sh});
      chk("alu_en", {opB_mux_sel, cc_en, reg_write, ext_op, mem_ren},
          {av[i].opb, av[i].ccen, 1'b1, 1'b0, 1'b0});
      tick();
      exp_ret = exp_ret + 4'd1;
      chk("alu_to_fetch", {fetch, retired}, {1'b1, exp_ret});
    end

    // LD R4,[R5,#2]: three wait cycles, ready on the WAIT_MAX cycle
    do_fetch(16'hD4A2);
    chk("ld_exec", {execute, reg_write, cc_en, opB_mux_sel, shift_op, alu_func, srcA},
        {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 3'd5});
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_wait", {memory, mem_ren, mem_wen, reg_write, dest}, {4'b1100, 3'd4});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_done", {memory, mem_ren, reg_write, bus_error, dest}, {4'b1110, 3'd4});
    tick();
    exp_ret = exp_ret + 4'd1;
    chk("ld_after", {fetch, bus_error}, 2'b10);
    chk("ld_retired", retired, exp_ret);

    // ST R3,[R1,#0] interrupted by reset while waiting in MEMORY
    do_fetch(16'hDB20);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("st_mem", {memory, mem_wen, mem_ren, reg_write, srcA, dest}, {4'b1100, 3'd3, 3'd3});
    tick();
    rst = 1'b1;
    #1;
    chk("st_rst", {fetch, memory, mem_wen, mem_ren}, 4'b1001);
    chk("st_rst_retired", retired, 0);
    tick();
    rst = 1'b0;
    exp_ret = 4'd0;

    // Timeout: ready never arrives in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_fetch", {fetch, bus_error}, 2'b10);
      tick();
    end
    #1;
    chk("to_error", bus_error, 1);
    chk("to_flags", {fetch, execute, memory, mem_ren, mem_wen, reg_write, cc_en, ext_op}, 8'h00);
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("to_sticky", {bus_error, fetch}, 2'b10);
    do_reset();
    chk("to_cleared", {bus_error, fetch, retired}, {2'b01, 4'd0});

    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 16; c++) begin
        do_fetch({3'b111, 1'b0, bv[i].cond, 8'h10});
        cc = 4'(c);
        #1;
        chk($sformatf("br_cond%0h_cc%0h", bv[i].cond, c), reg_write, bv[i].mask[c]);
        if (c == 0)
          chk("br_fields", {dest, srcA, ext_op, opB_mux_sel, cc_en, alu_func},
              {3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0});
        tick();
      end
    end

    // 17 instructions on a 4-bit counter
    do_reset();
    for (int n = 1; n <= 17; n++) begin
      do_fetch(16'h094C);
      tick();
      exp_ret = exp_ret + 4'd1;
      chk("wrap_retired", retired, exp_ret);
    end
    chk("wrap_final", retired, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
